// File: rtl/fft_pkg.sv
// Shared FFT definitions: default sample width, quarter/index helpers for
// radix-4 SDF stages, and the packed complex-sample type.
package fft_pkg;

    localparam int unsigned WIDTH_DEF = 32;

    typedef enum logic {
        PH_FILL,
        PH_COMPUTE
    } phase_t;

    typedef struct packed {
        logic [WIDTH_DEF-1:0] re;
        logic [WIDTH_DEF-1:0] im;
    } cplx_t;

    function automatic int unsigned quarter_len(input int unsigned n);
        return n / 4;
    endfunction

    function automatic int unsigned fill_len(input int unsigned n);
        return 3 * (n / 4);
    endfunction

    function automatic int unsigned clog2_n(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = 1; v < n; v = v << 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/r4_butterfly.sv
// Combinational 4-point DIF butterfly with a fixed 1/4 gain (floor shift),
// computed in WIDTH+2 bits so the sums can never overflow.
module r4_butterfly #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a_re,
    input  logic [WIDTH-1:0] i_a_im,
    input  logic [WIDTH-1:0] i_b_re,
    input  logic [WIDTH-1:0] i_b_im,
    input  logic [WIDTH-1:0] i_c_re,
    input  logic [WIDTH-1:0] i_c_im,
    input  logic [WIDTH-1:0] i_d_re,
    input  logic [WIDTH-1:0] i_d_im,
    output logic [WIDTH-1:0] o_x0_re,
    output logic [WIDTH-1:0] o_x0_im,
    output logic [WIDTH-1:0] o_x1_re,
    output logic [WIDTH-1:0] o_x1_im,
    output logic [WIDTH-1:0] o_x2_re,
    output logic [WIDTH-1:0] o_x2_im,
    output logic [WIDTH-1:0] o_x3_re,
    output logic [WIDTH-1:0] o_x3_im
);

    localparam int unsigned EW = WIDTH + 2;

    function automatic logic signed [EW-1:0] ext(input logic [WIDTH-1:0] v);
        return EW'($signed(v));
    endfunction

    // Dropping the two LSBs of the two's-complement sum is an arithmetic floor /4.
    function automatic logic [WIDTH-1:0] scale(input logic signed [EW-1:0] s);
        return s[EW-1:2];
    endfunction

    logic signed [EW-1:0] w_ar, w_ai, w_br, w_bi, w_cr, w_ci, w_dr, w_di;
    logic signed [EW-1:0] w_s0r, w_s0i, w_s1r, w_s1i, w_s2r, w_s2i, w_s3r, w_s3i;

    always_comb begin
        w_ar = ext(i_a_re);
        w_ai = ext(i_a_im);
        w_br = ext(i_b_re);
        w_bi = ext(i_b_im);
        w_cr = ext(i_c_re);
        w_ci = ext(i_c_im);
        w_dr = ext(i_d_re);
        w_di = ext(i_d_im);

        w_s0r = w_ar + w_br + w_cr + w_dr;
        w_s0i = w_ai + w_bi + w_ci + w_di;
        // -j*b = (b_im, -b_re), +j*d = (-d_im, d_re)
        w_s1r = w_ar + w_bi - w_cr - w_di;
        w_s1i = w_ai - w_br - w_ci + w_dr;
        w_s2r = w_ar - w_br + w_cr - w_dr;
        w_s2i = w_ai - w_bi + w_ci - w_di;
        w_s3r = w_ar - w_bi - w_cr + w_di;
        w_s3i = w_ai + w_br - w_ci - w_dr;
    end

    assign o_x0_re = scale(w_s0r);
    assign o_x0_im = scale(w_s0i);
    assign o_x1_re = scale(w_s1r);
    assign o_x1_im = scale(w_s1i);
    assign o_x2_re = scale(w_s2r);
    assign o_x2_im = scale(w_s2i);
    assign o_x3_re = scale(w_s3r);
    assign o_x3_im = scale(w_s3i);

endmodule

// File: rtl/r4_sdf_bf_front.sv
// Radix-4 SDF stage front end: buffers the first 3N/4 samples of each block and
// emits one registered 4-point butterfly per last-quarter sample.
module r4_sdf_bf_front
    import fft_pkg::*;
#(
    parameter int unsigned N     = 16,
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_re,
    input  logic [WIDTH-1:0] in_im,
    output logic             out_valid,
    output logic             out_first,
    output logic             out_last,
    output logic [WIDTH-1:0] out_re_0,
    output logic [WIDTH-1:0] out_re_1,
    output logic [WIDTH-1:0] out_re_2,
    output logic [WIDTH-1:0] out_re_3,
    output logic [WIDTH-1:0] out_im_0,
    output logic [WIDTH-1:0] out_im_1,
    output logic [WIDTH-1:0] out_im_2,
    output logic [WIDTH-1:0] out_im_3
);

    localparam int unsigned L  = quarter_len(N);
    localparam int unsigned L3 = fill_len(N);
    localparam int unsigned CW = clog2_n(N);

    localparam logic [CW-1:0] C_FIRST = CW'(L3);
    localparam logic [CW-1:0] C_LAST  = CW'(N - 1);

    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_sr [L3];
    logic [WIDTH-1:0]   r_out_re [4];
    logic [WIDTH-1:0]   r_out_im [4];
    logic               r_out_valid;
    logic               r_out_first;
    logic               r_out_last;

    phase_t             w_phase;
    logic [WIDTH-1:0]   w_x_re [4];
    logic [WIDTH-1:0]   w_x_im [4];

    assign w_phase = (r_cnt >= C_FIRST) ? PH_COMPUTE : PH_FILL;

    // Oldest quarter sits at the tail of the line, newest quarter arrives on the input.
    r4_butterfly #(
        .WIDTH (WIDTH)
    ) u_bf (
        .i_a_re  (r_sr[L3-1][2*WIDTH-1:WIDTH]),
        .i_a_im  (r_sr[L3-1][WIDTH-1:0]),
        .i_b_re  (r_sr[2*L-1][2*WIDTH-1:WIDTH]),
        .i_b_im  (r_sr[2*L-1][WIDTH-1:0]),
        .i_c_re  (r_sr[L-1][2*WIDTH-1:WIDTH]),
        .i_c_im  (r_sr[L-1][WIDTH-1:0]),
        .i_d_re  (in_re),
        .i_d_im  (in_im),
        .o_x0_re (w_x_re[0]),
        .o_x0_im (w_x_im[0]),
        .o_x1_re (w_x_re[1]),
        .o_x1_im (w_x_im[1]),
        .o_x2_re (w_x_re[2]),
        .o_x2_im (w_x_im[2]),
        .o_x3_re (w_x_re[3]),
        .o_x3_im (w_x_im[3])
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_first <= 1'b0;
            r_out_last  <= 1'b0;
            for (int unsigned i = 0; i < L3; i++) begin
                r_sr[i] <= '0;
            end
            for (int unsigned m = 0; m < 4; m++) begin
                r_out_re[m] <= '0;
                r_out_im[m] <= '0;
            end
        end else if (flush) begin
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_first <= 1'b0;
            r_out_last  <= 1'b0;
            for (int unsigned i = 0; i < L3; i++) begin
                r_sr[i] <= '0;
            end
            for (int unsigned m = 0; m < 4; m++) begin
                r_out_re[m] <= '0;
                r_out_im[m] <= '0;
            end
        end else begin
            r_out_valid <= 1'b0;
            r_out_first <= 1'b0;
            r_out_last  <= 1'b0;
            if (in_valid) begin
                r_cnt   <= r_cnt + CW'(1);
                r_sr[0] <= {in_re, in_im};
                for (int unsigned i = 1; i < L3; i++) begin
                    r_sr[i] <= r_sr[i-1];
                end
                if (w_phase == PH_COMPUTE) begin
                    r_out_valid <= 1'b1;
                    r_out_first <= (r_cnt == C_FIRST);
                    r_out_last  <= (r_cnt == C_LAST);
                    for (int unsigned m = 0; m < 4; m++) begin
                        r_out_re[m] <= w_x_re[m];
                        r_out_im[m] <= w_x_im[m];
                    end
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_first = r_out_first;
    assign out_last  = r_out_last;
    assign out_re_0  = r_out_re[0];
    assign out_re_1  = r_out_re[1];
    assign out_re_2  = r_out_re[2];
    assign out_re_3  = r_out_re[3];
    assign out_im_0  = r_out_im[0];
    assign out_im_1  = r_out_im[1];
    assign out_im_2  = r_out_im[2];
    assign out_im_3  = r_out_im[3];

endmodule

// File: tb/tb_r4_sdf_bf_front.sv
// Directed bench for r4_sdf_bf_front (N=16, WIDTH=32) with hand-computed butterfly results.
module tb_r4_sdf_bf_front;
    import fft_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_re = '0;
    logic [31:0] in_im = '0;
    logic        out_valid, out_first, out_last;
    logic [31:0] out_re_0, out_re_1, out_re_2, out_re_3;
    logic [31:0] out_im_0, out_im_1, out_im_2, out_im_3;

    int total = 0;
    int bad   = 0;

    cplx_t xs [16];
    cplx_t ex [4][4];

    r4_sdf_bf_front #(
        .N     (16),
        .WIDTH (32)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_first (out_first),
        .out_last  (out_last),
        .out_re_0  (out_re_0),
        .out_re_1  (out_re_1),
        .out_re_2  (out_re_2),
        .out_re_3  (out_re_3),
        .out_im_0  (out_im_0),
        .out_im_1  (out_im_1),
        .out_im_2  (out_im_2),
        .out_im_3  (out_im_3)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] get_re(input int m);
        case (m)
            0:       return out_re_0;
            1:       return out_re_1;
            2:       return out_re_2;
            default: return out_re_3;
        endcase
    endfunction

    function automatic logic [31:0] get_im(input int m);
        case (m)
            0:       return out_im_0;
            1:       return out_im_1;
            2:       return out_im_2;
            default: return out_im_3;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(expv));
        end
    endtask

    task automatic clear_vecs();
        for (int n = 0; n < 16; n++) xs[n] = '0;
        for (int k = 0; k < 4; k++)
            for (int m = 0; m < 4; m++) ex[k][m] = '0;
    endtask

    task automatic send(input logic [31:0] re, input logic [31:0] im);
        in_valid = 1'b1;
        in_re    = re;
        in_im    = im;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic run_block(input string name, input int gap);
        int k;
        for (int n = 0; n < 16; n++) begin
            for (int g = 0; g < gap; g++) begin
                idle();
                chk($sformatf("%s_n%0d_gap_valid", name, n), {31'b0, out_valid}, 32'd0);
            end
            send(xs[n].re, xs[n].im);
            if (n >= 12) begin
                k = n - 12;
                chk($sformatf("%s_k%0d_valid", name, k), {31'b0, out_valid}, 32'd1);
                chk($sformatf("%s_k%0d_first", name, k), {31'b0, out_first}, (k == 0) ? 32'd1 : 32'd0);
                chk($sformatf("%s_k%0d_last", name, k), {31'b0, out_last}, (k == 3) ? 32'd1 : 32'd0);
                for (int m = 0; m < 4; m++) begin
                    chk($sformatf("%s_k%0d_X%0d_re", name, k, m), get_re(m), ex[k][m].re);
                    chk($sformatf("%s_k%0d_X%0d_im", name, k, m), get_im(m), ex[k][m].im);
                end
            end else begin
                chk($sformatf("%s_n%0d_fill_valid", name, n), {31'b0, out_valid}, 32'd0);
            end
        end
    endtask

    task automatic set_dc();
        clear_vecs();
        for (int n = 0; n < 16; n++) xs[n].re = 32'd400;
        for (int k = 0; k < 4; k++) ex[k][0].re = 32'd400;
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_first", {31'b0, out_first}, 32'd0);
        chk("rst_last", {31'b0, out_last}, 32'd0);
        chk("rst_re0", out_re_0, 32'd0);
        chk("rst_im3", out_im_3, 32'd0);
        reset = 1'b0;
        idle();

        clear_vecs();
        xs[0].re = 32'd1000;
        for (int m = 0; m < 4; m++) ex[0][m].re = 32'd250;
        run_block("impulse", 0);

        set_dc();
        run_block("dc", 0);
        idle();
        chk("hold_valid", {31'b0, out_valid}, 32'd0);
        chk("hold_re0", out_re_0, 32'd400);

        clear_vecs();
        xs[4].im = 32'd400;
        ex[0][0].im = 32'd100;
        ex[0][1].re = 32'd100;
        ex[0][2].im = -32'sd100;
        ex[0][3].re = -32'sd100;
        run_block("jrot", 0);

        clear_vecs();
        xs[0].re = -32'sd1;
        xs[0].im = 32'd3;
        for (int m = 0; m < 4; m++) ex[0][m].re = -32'sd1;
        run_block("floor", 0);

        clear_vecs();
        for (int n = 0; n < 16; n++) xs[n].re = 32'h7FFF_FFFF;
        for (int k = 0; k < 4; k++) ex[k][0].re = 32'h7FFF_FFFF;
        run_block("fullscale", 0);

        set_dc();
        run_block("stall", 2);
        idle();
        chk("stall_after_valid", {31'b0, out_valid}, 32'd0);

        for (int n = 0; n < 7; n++) send(32'd999, 32'd77);
        reset = 1'b1;
        #1;
        chk("midrst_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_re0", out_re_0, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        set_dc();
        run_block("rst_b2b_a", 0);
        run_block("rst_b2b_b", 0);

        for (int n = 0; n < 7; n++) send(32'd999, 32'd77);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_re    = 32'd12345;
        in_im    = 32'd5;
        @(posedge clock);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_re0", out_re_0, 32'd0);
        run_block("fl_b2b_a", 0);
        run_block("fl_b2b_b", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
